// File: rtl/pe_pkg.sv
// Shared packetizer definitions: FSM states, packet-type encodings and field layout.
package pe_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_e;

  localparam logic IFMAP  = 1'b0;
  localparam logic FILTER = 1'b1;

  localparam int unsigned TS_BIT   = 0;
  localparam int unsigned TYPE_BIT = 1;
  localparam int unsigned ROW_LSB  = 2;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned DATA_LSB = 5;
  localparam int unsigned TAP_BITS = 5;

  function automatic int unsigned pkt_width(input int unsigned filter_width);
    return TAP_BITS * filter_width + DATA_LSB;
  endfunction

endpackage

// File: rtl/packet_fifo.sv
// Two-entry output queue; head entry is always presented on dout.
module packet_fifo #(
  parameter int unsigned WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             pop_c;
  logic             push_ok_c;

  assign pop_c     = valid_q && out_ready;
  assign push_ok_c = push && ((count_q != 2'd2) || pop_c);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_ok_c, pop_c})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps occupancy; the new entry lands behind the survivor.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = head_q;
  assign count     = count_q;

endmodule

// File: rtl/packetizer.sv
// Gathers type/row/data/timestep fields arriving in any order and emits one packet
// per complete set through a two-entry output queue.
module packetizer
  import pe_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned PKT_W        = pkt_width(FILTER_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ifmapb_filter_valid,
  output logic                      ifmapb_filter_ready,
  input  logic                      ifmapb_filter_in,
  input  logic                      filter_row_valid,
  output logic                      filter_row_ready,
  input  logic [ROW_W-1:0]          filter_row_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [TAP_BITS*FILTER_WIDTH-1:0] data_in,
  input  logic                      timestep_valid,
  output logic                      timestep_ready,
  input  logic                      timestep_in,
  output logic                      packet_valid,
  input  logic                      packet_ready,
  output logic [PKT_W-1:0]          packet_out
);

  localparam int unsigned DATA_W = TAP_BITS * FILTER_WIDTH;

  state_e            state_q, state_d;
  logic              ptype_q, ptype_d, ptype_full_q, ptype_full_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              row_full_q, row_full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_full_q, data_full_d;
  logic              ts_q, ts_d, ts_full_q, ts_full_d;
  logic              collect_c;
  logic              fifo_pop_c;
  logic              push_c;
  logic [1:0]        fifo_count;
  logic [PKT_W-1:0]  pkt_c;

  // Readies are forced low while reset is held.
  assign collect_c           = rst_n && (state_q == COLLECT);
  assign ifmapb_filter_ready = collect_c && !ptype_full_q;
  assign filter_row_ready    = collect_c && !row_full_q;
  assign data_ready          = collect_c && !data_full_q;
  assign timestep_ready      = collect_c && ptype_full_q && (ptype_q == IFMAP) && !ts_full_q;
  assign fifo_pop_c          = packet_valid && packet_ready;

  assign pkt_c = PKT_W'({data_q, row_q, ptype_q, (ptype_q == IFMAP) ? ts_q : 1'b0});

  always_comb begin
    state_d      = state_q;
    ptype_d      = ptype_q;
    ptype_full_d = ptype_full_q;
    row_d        = row_q;
    row_full_d   = row_full_q;
    data_d       = data_q;
    data_full_d  = data_full_q;
    ts_d         = ts_q;
    ts_full_d    = ts_full_q;
    push_c       = 1'b0;
    case (state_q)
      COLLECT: begin
        if (ifmapb_filter_valid && ifmapb_filter_ready) begin
          ptype_d      = ifmapb_filter_in;
          ptype_full_d = 1'b1;
        end
        if (filter_row_valid && filter_row_ready) begin
          row_d      = filter_row_in;
          row_full_d = 1'b1;
        end
        if (data_valid && data_ready) begin
          data_d      = data_in;
          data_full_d = 1'b1;
        end
        if (timestep_valid && timestep_ready) begin
          ts_d      = timestep_in;
          ts_full_d = 1'b1;
        end
        if (ptype_full_d && row_full_d && data_full_d && ((ptype_d == FILTER) || ts_full_d))
          state_d = ISSUE;
      end
      ISSUE: begin
        if ((fifo_count != 2'd2) || fifo_pop_c) begin
          push_c       = 1'b1;
          state_d      = COLLECT;
          ptype_full_d = 1'b0;
          row_full_d   = 1'b0;
          data_full_d  = 1'b0;
          ts_full_d    = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      ptype_q      <= 1'b0;
      ptype_full_q <= 1'b0;
      row_q        <= '0;
      row_full_q   <= 1'b0;
      data_q       <= '0;
      data_full_q  <= 1'b0;
      ts_q         <= 1'b0;
      ts_full_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptype_q      <= ptype_d;
      ptype_full_q <= ptype_full_d;
      row_q        <= row_d;
      row_full_q   <= row_full_d;
      data_q       <= data_d;
      data_full_q  <= data_full_d;
      ts_q         <= ts_d;
      ts_full_q    <= ts_full_d;
    end
  end

  packet_fifo #(.WIDTH(PKT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .din       (pkt_c),
    .out_ready (packet_ready),
    .out_valid (packet_valid),
    .dout      (packet_out),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_packetizer.sv
// Randomized scoreboard bench for packetizer: queue-based field model, decoupled monitor.
`timescale 1ns/1ps
module tb_packetizer;
  import pe_pkg::*;

  localparam int unsigned FW = 8;
  localparam int unsigned DW = 5 * FW;
  localparam int unsigned PW = DW + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifmapb_filter_valid = 1'b0, ifmapb_filter_ready, ifmapb_filter_in = 1'b0;
  logic          filter_row_valid = 1'b0, filter_row_ready;
  logic [2:0]    filter_row_in = '0;
  logic          data_valid = 1'b0, data_ready;
  logic [DW-1:0] data_in = '0;
  logic          timestep_valid = 1'b0, timestep_ready, timestep_in = 1'b0;
  logic          packet_valid, packet_ready = 1'b0;
  logic [PW-1:0] packet_out;

  packetizer #(.FILTER_WIDTH(FW), .PKT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifmapb_filter_valid(ifmapb_filter_valid), .ifmapb_filter_ready(ifmapb_filter_ready),
    .ifmapb_filter_in(ifmapb_filter_in),
    .filter_row_valid(filter_row_valid), .filter_row_ready(filter_row_ready),
    .filter_row_in(filter_row_in),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .timestep_valid(timestep_valid), .timestep_ready(timestep_ready), .timestep_in(timestep_in),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_out(packet_out)
  );

  always #5 clk = ~clk;

  // Per-channel pending values, the reference model's ts queue and expected packets.
  bit            ty_s[$];
  logic [2:0]    row_s[$];
  logic [DW-1:0] dat_s[$];
  bit            ts_s[$];
  bit            model_ts[$];
  logic [PW-1:0] exp_q[$];

  int  errors = 0, checks = 0;
  int  density = 100, rdy_density = 100;
  bit  hold_ty = 0, hold_row = 0, hold_dat = 0, hold_ts = 0;
  int  cyc = 0, last_hs_cyc = 0, first_valid_cyc = 0, pkts_out = 0, ts_rdy_seen = 0;
  bit  valid_prev = 0, stalled = 0;
  logic [PW-1:0] held_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic add_ts(input bit v);
    ts_s.push_back(v);
    model_ts.push_back(v);
  endtask

  // Packet fields pass through; ifmap packets take the oldest pending timestep.
  task automatic add_pkt(input bit ty, input logic [2:0] row, input logic [DW-1:0] d);
    bit ts = 1'b0;
    ty_s.push_back(ty);
    row_s.push_back(row);
    dat_s.push_back(d);
    if (ty == 1'b0) ts = model_ts.pop_front();
    exp_q.push_back({d, row, ty, ts});
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_out < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pkts_out < target) begin
      errors++;
      $display("FAIL timeout: packets got=%0d expected=%0d", pkts_out, target);
    end
  endtask

  // Driver: retire handshaken values, then present the next head of each channel.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ifmapb_filter_valid && ifmapb_filter_ready) begin ty_s.delete(0);  last_hs_cyc = cyc; end
      if (filter_row_valid && filter_row_ready)       begin row_s.delete(0); last_hs_cyc = cyc; end
      if (data_valid && data_ready)                   begin dat_s.delete(0); last_hs_cyc = cyc; end
      if (timestep_valid && timestep_ready)           begin ts_s.delete(0);  last_hs_cyc = cyc; end
    end
    @(posedge clk);
    #1;
    ifmapb_filter_valid = ty_s.size() > 0 && !hold_ty && (int'($urandom_range(99)) < density);
    ifmapb_filter_in    = ty_s.size() > 0 ? ty_s[0] : 1'b0;
    filter_row_valid    = row_s.size() > 0 && !hold_row && (int'($urandom_range(99)) < density);
    filter_row_in       = row_s.size() > 0 ? row_s[0] : 3'd0;
    data_valid          = dat_s.size() > 0 && !hold_dat && (int'($urandom_range(99)) < density);
    data_in             = dat_s.size() > 0 ? dat_s[0] : '0;
    timestep_valid      = ts_s.size() > 0 && !hold_ts && (int'($urandom_range(99)) < density);
    timestep_in         = ts_s.size() > 0 ? ts_s[0] : 1'b0;
    packet_ready        = int'($urandom_range(99)) < rdy_density;
  end

  // Monitor: compare every delivered packet against the scoreboard; check stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (timestep_ready) ts_rdy_seen++;
      if (stalled) begin
        checks++;
        if (!packet_valid || packet_out !== held_out) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b out=%0h expected v=1 out=%0h",
                   packet_valid, packet_out, held_out);
        end
      end
      if (packet_valid && !valid_prev) first_valid_cyc = cyc;
      if (packet_valid && packet_ready) begin
        checks++;
        pkts_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pkt: got=%0h expected none", packet_out);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          if (packet_out !== e) begin
            errors++;
            $display("FAIL pkt_data: got=%0h expected=%0h", packet_out, e);
          end
        end
      end
      stalled    = packet_valid && !packet_ready;
      held_out   = packet_out;
      valid_prev = packet_valid;
    end else begin
      stalled    = 0;
      valid_prev = 0;
    end
  end

  initial begin
    int base, c0, n;
    repeat (3) @(negedge clk);
    check("rst_valid", packet_valid, 0);
    check("rst_out", packet_out, 0);
    check("rst_readies", {ifmapb_filter_ready, filter_row_ready, data_ready, timestep_ready}, 0);
    #1 rst_n = 1'b1;

    // Ifmap packet, fields offered together; timestep follows once the type is held.
    add_ts(1'b1);
    add_pkt(1'b0, 3'd3, 40'h123456789A);
    base = pkts_out;
    wait_pkts(base + 1, 40);
    check("ifmap_latency", 64'(first_valid_cyc - last_hs_cyc), 2);

    // Filter packet with an early timestep that must stay pending.
    ts_rdy_seen = 0;
    add_ts(1'b1);
    add_pkt(1'b1, 3'd2, 40'hFF00FF00FF);
    base = pkts_out;
    wait_pkts(base + 1, 40);
    check("filter_latency", 64'(first_valid_cyc - last_hs_cyc), 2);
    repeat (3) @(posedge clk);
    check("filter_ts_ready", ts_rdy_seen, 0);
    check("filter_ts_pending", ts_s.size(), 1);
    add_pkt(1'b0, 3'd5, 40'hA5A5_0000_01);
    base = pkts_out;
    wait_pkts(base + 1, 40);

    // Out-of-order fields: data@0, row@3, type@5, ts@7 -> valid@9.
    hold_ty = 1; hold_row = 1; hold_dat = 1; hold_ts = 1;
    add_ts(1'b0);
    add_pkt(1'b0, 3'd6, 40'h0123_4567_89);
    base = pkts_out;
    @(posedge clk); hold_dat = 0;
    @(negedge clk); c0 = cyc;
    repeat (3) @(posedge clk); hold_row = 0;
    repeat (2) @(posedge clk); hold_ty = 0;
    repeat (2) @(posedge clk); hold_ts = 0;
    wait_pkts(base + 1, 40);
    check("ooo_valid_cycle", 64'(first_valid_cyc - c0), 9);
    repeat (5) @(posedge clk);
    check("ooo_one_pkt", pkts_out, base + 1);

    // Backpressure: two queued, third stuck in ISSUE; then a simultaneous push/pop.
    @(posedge clk); rdy_density = 0;
    add_pkt(1'b1, 3'd1, 40'h11_1111_1111);
    add_ts(1'b1);
    add_pkt(1'b0, 3'd7, 40'h22_2222_2222);
    add_pkt(1'b1, 3'd4, 40'h33_3333_3333);
    base = pkts_out;
    repeat (25) @(posedge clk);
    check("bp_no_emit", pkts_out, base);
    check("bp_fields_taken", ty_s.size() + row_s.size() + dat_s.size() + ts_s.size(), 0);
    @(negedge clk);
    check("bp_readies_low", {ifmapb_filter_ready, filter_row_ready, data_ready, timestep_ready}, 0);
    check("bp_valid", packet_valid, 1);
    @(posedge clk); rdy_density = 100;
    @(posedge clk); rdy_density = 0;
    repeat (5) @(posedge clk);
    check("full_pushpop_one", pkts_out, base + 1);
    rdy_density = 100;
    wait_pkts(base + 3, 40);

    // Reset while a packet sits in ISSUE and one is queued.
    @(posedge clk); rdy_density = 0;
    add_pkt(1'b1, 3'd0, 40'hAA_AAAA_AAAA);
    n = 0;
    while (!packet_valid && n < 30) begin @(posedge clk); n++; end
    check("rst_a_queued", packet_valid, 1);
    add_pkt(1'b1, 3'd1, 40'hBB_BBBB_BBBB);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while ((ty_s.size() + row_s.size() + dat_s.size()) != 0 && n < 30);
    @(negedge clk);
    check("rst_in_issue", {ifmapb_filter_ready, filter_row_ready, data_ready}, 0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_ts.delete();
    base = pkts_out;
    @(negedge clk);
    check("midrst_valid", packet_valid, 0);
    check("midrst_readies", {ifmapb_filter_ready, filter_row_ready, data_ready, timestep_ready}, 0);
    #1 rst_n = 1'b1;
    rdy_density = 100;
    repeat (10) @(posedge clk);
    check("midrst_discard", pkts_out, base);
    add_ts(1'b1);
    add_pkt(1'b0, 3'd2, 40'hC0FF_EE12_34);
    wait_pkts(base + 1, 40);

    // Randomized traffic with random gaps and backpressure.
    density = 60;
    rdy_density = 70;
    base = pkts_out;
    for (int i = 0; i < 40; i++) begin
      bit ty;
      ty = 1'($urandom_range(1));
      if (ty == 1'b0) add_ts(1'($urandom_range(1)));
      add_pkt(ty, 3'($urandom_range(7)), DW'({$urandom(), $urandom()}));
    end
    wait_pkts(base + 40, 3000);
    repeat (5) @(posedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_ts_consumed", ts_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
